msi_dir_controller: RTL and testbench

- Directory controller for the two-cache MSI system. It arbitrates coherence requests from Cache1 and Cache2 and serializes them, one transaction at a time, against a small directory table.
- It issues Invalidate / Fetch / FetchInvalidate messages to the other cache, sequences writebacks, and returns the granted line state to the requester.
- It sits between the cache controllers and memory, and is the block that sequences the directory datapath exercised by the MSI testbench cases.

---
 rtl/msi_pkg.sv | 48 ++++
 rtl/msi_rr_arbiter.sv | 48 ++++
 rtl/msi_dir_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_msi_dir_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// ============================================================================
// Module      : msi_pkg
// Description : Shared encodings for the two-cache MSI directory controller:
//               line/directory states, request and forward op codes,
//               requester ids and the controller FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package msi_pkg;

  // Cache / directory line states
  localparam logic [2:0] c_ST_I = 3'b001;
  localparam logic [2:0] c_ST_S = 3'b010;
  localparam logic [2:0] c_ST_M = 3'b011;

  // Request op codes from a cache controller
  localparam logic [1:0] c_OP_READ_MISS  = 2'b00;
  localparam logic [1:0] c_OP_WRITE_MISS = 2'b01;
  localparam logic [1:0] c_OP_UPGRADE    = 2'b10;
  localparam logic [1:0] c_OP_RESERVED   = 2'b11;

  // Forward op codes sent to the non-requesting cache
  localparam logic [1:0] c_FWD_NONE      = 2'b00;
  localparam logic [1:0] c_FWD_INV       = 2'b01;
  localparam logic [1:0] c_FWD_FETCH     = 2'b10;
  localparam logic [1:0] c_FWD_FETCH_INV = 2'b11;

  // Requester ids
  localparam logic c_REQ_CACHE1 = 1'b0;
  localparam logic c_REQ_CACHE2 = 1'b1;

  typedef enum logic [2:0] {
    FSM_IDLE   = 3'd0,
    FSM_LOOKUP = 3'd1,
    FSM_FWD    = 3'd2,
    FSM_WB     = 3'd3,
    FSM_RESP   = 3'd4
  } fsm_state_t;

  // Requester id -> sharers bit mask
  function automatic logic [1:0] id_onehot(input logic id);
    return (id == c_REQ_CACHE2) ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msi_rr_arbiter.sv
// ============================================================================
// Module      : msi_rr_arbiter
// Description : Two-input round-robin arbiter with a registered priority
//               pointer and a one-hot combinational grant.
// Ports       : clk       - system clock, rising edge
//               rst_n     - synchronous active-low reset (pointer -> Cache1)
//               i_req     - request vector, bit0 Cache1, bit1 Cache2
//               i_accept  - grant taken on this edge
//               o_grant   - one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msi_rr_arbiter
  import msi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // Requester that wins the next contended round
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_ptr == c_REQ_CACHE2) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  // Priority only moves when both requesters actually contended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= c_REQ_CACHE1;
    end else if (i_accept && (i_req == 2'b11)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/msi_dir_controller.sv
// ============================================================================
// Module      : msi_dir_controller
// Description : Directory controller for a two-cache MSI system. Arbitrates
//               Cache1/Cache2 requests, serializes one transaction at a time
//               against the directory, issues forwards to the other cache,
//               sequences writebacks and returns the granted line state.
// Ports       : Clock, Reset_n (sync, active-low)
//               req_valid/req_op0/req_op1/req_addr0/req_addr1 -> requests
//               req_ready  - one-hot grant (IDLE only)
//               fwd_*      - forward message and its acknowledge
//               wb_valid/wb_addr   - one-cycle writeback pulse
//               rsp_valid/rsp_dst/rsp_state - transaction completion
//               stat_txn/stat_inv/stat_wb  - only with MSI_DIR_STATS_EN
// Options     : MSI_DIR_STATS_EN - adds 16-bit saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msi_dir_controller
  import msi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ready,
  output logic              fwd_valid,
  output logic [1:0]        fwd_op,
  output logic              fwd_dst,
  output logic [ADDR_W-1:0] fwd_addr,
  input  logic              fwd_ack,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              rsp_valid,
  output logic              rsp_dst,
  output logic [2:0]        rsp_state
`ifdef MSI_DIR_STATS_EN
  ,
  output logic [15:0]       stat_txn,
  output logic [15:0]       stat_inv,
  output logic [15:0]       stat_wb
`endif
);

  fsm_state_t r_state;
  fsm_state_t w_state_nxt;

  // Directory table
  logic [2:0]        r_dir_state [NUM_LINES];
  logic [1:0]        r_dir_sh    [NUM_LINES];

  // Open transaction
  logic              r_req_id;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_fwd_op;
  logic [2:0]        r_new_state;
  logic [1:0]        r_new_sh;

  logic [1:0]        w_req_eff;
  logic [1:0]        w_grant;
  logic              w_accept;

  logic [2:0]        w_cur_state;
  logic [1:0]        w_cur_sh;
  logic [1:0]        w_r;
  logic [1:0]        w_o;
  logic [1:0]        w_act_fwd;
  logic              w_act_wb;
  logic [2:0]        w_act_state;
  logic [1:0]        w_act_sh;

  // Reserved op is treated as no request at all.
  assign w_req_eff[0] = req_valid[0] && (req_op0 != c_OP_RESERVED);
  assign w_req_eff[1] = req_valid[1] && (req_op1 != c_OP_RESERVED);

  // Grants are withheld while reset is asserted so req_ready reads 00.
  assign w_accept = (r_state == FSM_IDLE) && Reset_n && (w_grant != 2'b00);

  msi_rr_arbiter u_arb (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .i_req    (w_req_eff),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // Action decode for the latched request against the current entry.
  always_comb begin
    w_cur_state = r_dir_state[r_addr];
    w_cur_sh    = r_dir_sh[r_addr];
    w_r         = id_onehot(r_req_id);
    w_o         = id_onehot(~r_req_id);
    w_act_fwd   = c_FWD_NONE;
    w_act_wb    = 1'b0;
    w_act_state = c_ST_M;
    w_act_sh    = w_r;
    if (r_op == c_OP_READ_MISS) begin
      w_act_state = c_ST_S;
      case (w_cur_state)
        c_ST_S: w_act_sh = w_cur_sh | w_r;
        c_ST_M: begin
          // Dirty line: always written back; fetched first if the other
          // cache owns it, which then keeps a shared copy.
          w_act_wb = 1'b1;
          if ((w_cur_sh & w_r) == 2'b00) begin
            w_act_fwd = c_FWD_FETCH;
            w_act_sh  = w_r | w_o;
          end
        end
        default: w_act_sh = w_r;
      endcase
    end else begin
      // WriteMiss and Upgrade share one path; the requester ends as owner.
      case (w_cur_state)
        c_ST_S: begin
          if ((w_cur_sh & w_o) != 2'b00) begin
            w_act_fwd = c_FWD_INV;
          end
        end
        c_ST_M: begin
          w_act_wb = 1'b1;
          if ((w_cur_sh & w_r) == 2'b00) begin
            w_act_fwd = c_FWD_FETCH_INV;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= FSM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FSM_IDLE: begin
        if (w_accept) w_state_nxt = FSM_LOOKUP;
      end
      FSM_LOOKUP: begin
        if (w_act_fwd != c_FWD_NONE) w_state_nxt = FSM_FWD;
        else if (w_act_wb)           w_state_nxt = FSM_WB;
        else                         w_state_nxt = FSM_RESP;
      end
      FSM_FWD: begin
        if (fwd_ack) begin
          w_state_nxt = (r_fwd_op == c_FWD_INV) ? FSM_RESP : FSM_WB;
        end
      end
      FSM_WB:   w_state_nxt = FSM_RESP;
      FSM_RESP: w_state_nxt = FSM_IDLE;
      default:  w_state_nxt = FSM_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_req_id    <= c_REQ_CACHE1;
      r_op        <= c_OP_READ_MISS;
      r_addr      <= '0;
      r_fwd_op    <= c_FWD_NONE;
      r_new_state <= c_ST_I;
      r_new_sh    <= 2'b00;
    end else begin
      if (w_accept) begin
        r_req_id <= w_grant[1] ? c_REQ_CACHE2 : c_REQ_CACHE1;
        r_op     <= w_grant[1] ? req_op1 : req_op0;
        r_addr   <= w_grant[1] ? req_addr1 : req_addr0;
      end
      if (r_state == FSM_LOOKUP) begin
        r_fwd_op    <= w_act_fwd;
        r_new_state <= w_act_state;
        r_new_sh    <= w_act_sh;
      end
    end
  end

  // Entry is committed only on the RESP edge, so an abandoned
  // transaction leaves the table untouched (reset clears it anyway).
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_dir_state[i] <= c_ST_I;
        r_dir_sh[i]    <= 2'b00;
      end
    end else if (r_state == FSM_RESP) begin
      r_dir_state[r_addr] <= r_new_state;
      r_dir_sh[r_addr]    <= r_new_sh;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    fwd_valid = 1'b0;
    fwd_op    = c_FWD_NONE;
    fwd_dst   = 1'b0;
    fwd_addr  = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    rsp_valid = 1'b0;
    rsp_dst   = 1'b0;
    rsp_state = 3'b000;
    if (w_accept) req_ready = w_grant;
    case (r_state)
      FSM_FWD: begin
        fwd_valid = 1'b1;
        fwd_op    = r_fwd_op;
        fwd_dst   = ~r_req_id;
        fwd_addr  = r_addr;
      end
      FSM_WB: begin
        wb_valid = 1'b1;
        wb_addr  = r_addr;
      end
      FSM_RESP: begin
        rsp_valid = 1'b1;
        rsp_dst   = r_req_id;
        rsp_state = r_new_state;
      end
      default: ;
    endcase
  end

`ifdef MSI_DIR_STATS_EN
  logic [15:0] r_stat_txn;
  logic [15:0] r_stat_inv;
  logic [15:0] r_stat_wb;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_stat_txn <= 16'd0;
      r_stat_inv <= 16'd0;
      r_stat_wb  <= 16'd0;
    end else begin
      if ((r_state == FSM_RESP) && (r_stat_txn != 16'hFFFF)) begin
        r_stat_txn <= r_stat_txn + 16'd1;
      end
      // A forward is counted once, when it completes.
      if ((r_state == FSM_FWD) && fwd_ack &&
          ((r_fwd_op == c_FWD_INV) || (r_fwd_op == c_FWD_FETCH_INV)) &&
          (r_stat_inv != 16'hFFFF)) begin
        r_stat_inv <= r_stat_inv + 16'd1;
      end
      if ((r_state == FSM_WB) && (r_stat_wb != 16'hFFFF)) begin
        r_stat_wb <= r_stat_wb + 16'd1;
      end
    end
  end

  assign stat_txn = r_stat_txn;
  assign stat_inv = r_stat_inv;
  assign stat_wb  = r_stat_wb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_msi_dir_controller.sv
// ============================================================================
// Module      : tb_msi_dir_controller
// Description : Self-checking bench for msi_dir_controller. A directory
//               model (per-line state and sharers mask plus the round-robin
//               pointer) predicts grant, forward, writeback, response and
//               latency for each transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msi_dir_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_op0, req_op1;
  logic [1:0] req_addr0, req_addr1;
  logic [1:0] req_ready;
  logic       fwd_valid;
  logic [1:0] fwd_op;
  logic       fwd_dst;
  logic [1:0] fwd_addr;
  logic       fwd_ack;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic       rsp_valid;
  logic       rsp_dst;
  logic [2:0] rsp_state;
`ifdef MSI_DIR_STATS_EN
  logic [15:0] stat_txn, stat_inv, stat_wb;
`endif

  always #5 clk = ~clk;

  msi_dir_controller #(.NUM_LINES(4), .ADDR_W(2)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .req_valid (req_valid),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_ready (req_ready),
    .fwd_valid (fwd_valid),
    .fwd_op    (fwd_op),
    .fwd_dst   (fwd_dst),
    .fwd_addr  (fwd_addr),
    .fwd_ack   (fwd_ack),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .rsp_valid (rsp_valid),
    .rsp_dst   (rsp_dst),
    .rsp_state (rsp_state)
`ifdef MSI_DIR_STATS_EN
    ,
    .stat_txn  (stat_txn),
    .stat_inv  (stat_inv),
    .stat_wb   (stat_wb)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: 1=I 2=S 3=M, sharers as a 2-bit mask, pointer 0/1.
  int m_state [4];
  int m_sh    [4];
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = 1;
      m_sh[i]    = 0;
    end
    m_ptr = 0;
  endtask

  // One arbitration round plus the whole resulting transaction.
  task automatic do_txn(input logic v0, input logic [1:0] o0, input logic [1:0] a0,
                        input logic v1, input logic [1:0] o1, input logic [1:0] a1,
                        input int dly, input string tag, output logic [1:0] got_rdy);
    bit e0, e1, bad_rdy, bad_fwd;
    int win, op, a, r, o, st, sh, ns, nsh, x_fwd, x_wb, x_lat;
    int cyc, fwd_cnt, wb_cnt, rsp_cyc;
    logic [1:0] x_rdy, f_op, f_addr, w_a;
    logic f_dst, r_dst;
    logic [2:0] r_st;
    @(negedge clk);
    req_valid = {v1, v0};
    req_op0 = o0; req_addr0 = a0;
    req_op1 = o1; req_addr1 = a1;
    fwd_ack = 1'b0;
    #1;
    got_rdy = req_ready;
    e0 = v0 && (o0 != 2'b11);
    e1 = v1 && (o1 != 2'b11);
    if (!e0 && !e1) begin
      n_chk++;
      if (req_ready !== 2'b00) $display("FAIL %s idle_ready: got %b want 00", tag, req_ready);
      else n_pass++;
      return;
    end
    if (e0 && e1) begin
      win = m_ptr;
      m_ptr = 1 - m_ptr;
    end else begin
      win = e0 ? 0 : 1;
    end
    x_rdy = (win == 1) ? 2'b10 : 2'b01;
    n_chk++;
    if (req_ready !== x_rdy) $display("FAIL %s grant: got %b want %b", tag, req_ready, x_rdy);
    else n_pass++;

    op = (win == 1) ? int'(o1) : int'(o0);
    a  = (win == 1) ? int'(a1) : int'(a0);
    r  = 1 << win;
    o  = 1 << (1 - win);
    st = m_state[a];
    sh = m_sh[a];
    x_fwd = 0; x_wb = 0;
    if (op == 0) begin
      ns = 2;
      if (st == 1)      nsh = r;
      else if (st == 2) nsh = sh | r;
      else begin
        x_wb = 1;
        if (sh == o) begin x_fwd = 2; nsh = r | o; end
        else nsh = r;
      end
    end else begin
      ns = 3; nsh = r;
      if (st == 2 && (sh & o) != 0) x_fwd = 1;
      if (st == 3) begin
        x_wb = 1;
        if (sh == o) x_fwd = 3;
      end
    end
    m_state[a] = ns;
    m_sh[a]    = nsh;
    x_lat = 2 + x_wb + ((x_fwd != 0) ? 1 + dly : 0);

    cyc = 0; fwd_cnt = 0; wb_cnt = 0; rsp_cyc = -1;
    bad_rdy = 0; bad_fwd = 0;
    f_op = 0; f_dst = 0; f_addr = 0; w_a = 0; r_dst = 0; r_st = 0;
    while (rsp_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid[win] = 1'b0;
      #1;
      if (req_ready !== 2'b00) bad_rdy = 1;
      if (fwd_valid === 1'b1) begin
        fwd_cnt++;
        if (fwd_cnt == 1) begin
          f_op = fwd_op; f_dst = fwd_dst; f_addr = fwd_addr;
        end else if (fwd_op !== f_op || fwd_dst !== f_dst || fwd_addr !== f_addr) begin
          bad_fwd = 1;
        end
        fwd_ack = (fwd_cnt - 1 >= dly);
      end else begin
        fwd_ack = 1'($urandom_range(0, 1));
      end
      if (wb_valid === 1'b1) begin
        wb_cnt++;
        w_a = wb_addr;
      end
      if (rsp_valid === 1'b1) begin
        rsp_cyc = cyc;
        r_dst = rsp_dst;
        r_st  = rsp_state;
      end
    end
    fwd_ack = 1'b0;

    n_chk++;
    if (rsp_cyc < 0) begin
      $display("FAIL %s rsp_timeout: got none want rsp within 40 cycles", tag);
      return;
    end
    n_pass++;
    n_chk++;
    if (rsp_cyc != x_lat) $display("FAIL %s latency: got %0d want %0d", tag, rsp_cyc, x_lat);
    else n_pass++;
    n_chk++;
    if (r_dst !== 1'(win)) $display("FAIL %s rsp_dst: got %0d want %0d", tag, r_dst, win);
    else n_pass++;
    n_chk++;
    if (r_st !== 3'(ns)) $display("FAIL %s rsp_state: got %b want %b", tag, r_st, 3'(ns));
    else n_pass++;
    n_chk++;
    if (fwd_cnt != ((x_fwd != 0) ? 1 + dly : 0))
      $display("FAIL %s fwd_cycles: got %0d want %0d", tag, fwd_cnt, (x_fwd != 0) ? 1 + dly : 0);
    else n_pass++;
    if (x_fwd != 0) begin
      n_chk++;
      if (f_op !== 2'(x_fwd) || f_dst !== 1'(1 - win) || f_addr !== 2'(a) || bad_fwd)
        $display("FAIL %s fwd_msg: got op=%b dst=%0d addr=%0d unstable=%0d want op=%b dst=%0d addr=%0d",
                 tag, f_op, f_dst, f_addr, bad_fwd, 2'(x_fwd), 1 - win, a);
      else n_pass++;
    end
    n_chk++;
    if (wb_cnt != x_wb || (x_wb == 1 && w_a !== 2'(a)))
      $display("FAIL %s writeback: got cnt=%0d addr=%0d want cnt=%0d addr=%0d", tag, wb_cnt, w_a, x_wb, a);
    else n_pass++;
    n_chk++;
    if (bad_rdy) $display("FAIL %s ready_busy: got nonzero want 00 outside IDLE", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [1:0] g;
    rst_n = 1'b0;
    req_valid = 2'b11; req_op0 = 2'b00; req_op1 = 2'b00;
    req_addr0 = 2'd0; req_addr1 = 2'd0; fwd_ack = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (req_ready !== 2'b00 || fwd_valid !== 1'b0 || wb_valid !== 1'b0 || rsp_valid !== 1'b0)
        $display("FAIL reset_outputs: got rdy=%b fwd=%b wb=%b rsp=%b want all 0",
                 req_ready, fwd_valid, wb_valid, rsp_valid);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    do_txn(1, 2'b00, 2'd0, 0, 2'b00, 2'd0, 0, "rd_I_c1", g);
    do_txn(1, 2'b00, 2'd1, 1, 2'b00, 2'd1, 0, "rr_after_reset", g);
    do_txn(0, 2'b00, 2'd0, 1, 2'b00, 2'd1, 0, "rd_S_c2", g);
  endtask

  task automatic test_directed();
    logic [1:0] g;
    do_txn(1, 2'b10, 2'd1, 0, 2'b00, 2'd0, 2, "upg_S_inv", g);
    do_txn(0, 2'b00, 2'd0, 1, 2'b01, 2'd2, 0, "wr_I_c2", g);
    do_txn(1, 2'b00, 2'd2, 0, 2'b00, 2'd0, 1, "rd_M_fetch", g);
    do_txn(1, 2'b01, 2'd3, 0, 2'b00, 2'd0, 0, "wr_I_c1", g);
    do_txn(1, 2'b01, 2'd3, 0, 2'b00, 2'd0, 0, "wr_M_own", g);
    do_txn(0, 2'b00, 2'd0, 1, 2'b01, 2'd0, 0, "wr_S_inv", g);
    do_txn(0, 2'b00, 2'd0, 1, 2'b10, 2'd2, 1, "upg_S11", g);
    do_txn(1, 2'b01, 2'd2, 0, 2'b00, 2'd0, 0, "wr_M_finv", g);
    do_txn(1, 2'b11, 2'd1, 0, 2'b00, 2'd0, 0, "reserved_op", g);
  endtask

  task automatic test_random();
    logic [1:0] g;
    logic       pv [2];
    logic [1:0] po [2];
    logic [1:0] pa [2];
    int w;
    for (int i = 0; i < 2; i++) begin pv[i] = 0; po[i] = 0; pa[i] = 0; end
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] || po[i] == 2'b11) begin
          pv[i] = ($urandom_range(0, 3) != 0);
          po[i] = 2'($urandom_range(0, 3));
          pa[i] = 2'($urandom_range(0, 3));
        end
      end
      do_txn(pv[0], po[0], pa[0], pv[1], po[1], pa[1], $urandom_range(0, 3), "random", g);
      w = (g == 2'b10) ? 1 : ((g == 2'b01) ? 0 : -1);
      if (w >= 0) pv[w] = 0;
    end
    // Drain whatever request is still pending so later tests start clean.
    for (int i = 0; i < 2; i++) begin
      if (pv[i] && po[i] != 2'b11) begin
        if (i == 0) do_txn(1, po[0], pa[0], 0, 2'b00, 2'd0, 0, "drain", g);
        else        do_txn(0, 2'b00, 2'd0, 1, po[1], pa[1], 0, "drain", g);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] g, prev;
    logic [1:0] ad;
    ad = 2'($urandom_range(0, 3));
    prev = 2'b00;
    for (int k = 0; k < 8; k++) begin
      do_txn(1, 2'b00, ad, 1, 2'b00, ad, 0, "b2b", g);
      if (k > 0) begin
        n_chk++;
        if (g === prev || (g !== 2'b01 && g !== 2'b10))
          $display("FAIL b2b_alternate: got %b want opposite of %b", g, prev);
        else n_pass++;
      end
      prev = g;
    end
  endtask

  task automatic test_reset_in_fwd();
    logic [1:0] g;
    bit stray;
    do_txn(1, 2'b01, 2'd0, 0, 2'b00, 2'd0, 0, "pre_m0", g);
    do_txn(1, 2'b01, 2'd1, 0, 2'b00, 2'd0, 0, "pre_m1", g);
    do_txn(0, 2'b00, 2'd0, 1, 2'b01, 2'd2, 0, "pre_m2", g);
    do_txn(1, 2'b01, 2'd3, 0, 2'b00, 2'd0, 0, "pre_m3", g);
    @(negedge clk);
    req_valid = 2'b01; req_op0 = 2'b00; req_addr0 = 2'd2; fwd_ack = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) $display("FAIL rstfwd_grant: got %b want 01", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_chk++;
    if (fwd_valid !== 1'b1 || fwd_op !== 2'b10 || fwd_dst !== 1'b1)
      $display("FAIL rstfwd_in_fwd: got valid=%b op=%b dst=%b want 1/10/1", fwd_valid, fwd_op, fwd_dst);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (fwd_valid !== 1'b0 || rsp_valid !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 2'b00)
      $display("FAIL rstfwd_abandon: got fwd=%b rsp=%b wb=%b rdy=%b want all 0",
               fwd_valid, rsp_valid, wb_valid, req_ready);
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0 || wb_valid !== 1'b0 || fwd_valid !== 1'b0) stray = 1;
    end
    n_chk++;
    if (stray) $display("FAIL rstfwd_quiet: got activity after reset want none");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 2'b00, 2'd0, 1, 2'b01, 2'(i), 0, "post_reset_I", g);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_op0 = 2'b00; req_op1 = 2'b00;
    req_addr0 = 2'd0; req_addr1 = 2'd0; fwd_ack = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_in_fwd();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
